// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit: one outstanding word transfer using a req/ack handshake.
// The master (access unit) holds mem_req and the request fields stable until the slave (memory) pulses mem_ack.
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Word-wide memory access sequencer between the multicycle RISC-V controller and a variable-latency memory.
// It stalls the controller while an access is in flight, and it parks in a sticky error state on a fault.
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                done,
  output logic                busy,
  output logic                err,
  mem_access_unit_if.master   mem
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          req_q,   req_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic req_in;
  logic req_bad;

  assign req_in  = rd_en | wr_en;
  assign req_bad = (rd_en & wr_en) | (addr[1:0] != 2'b00);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req_in) begin
          if (req_bad) begin
            state_d = S_ERR;
          end else begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            we_d    = wr_en;
            addr_d  = addr;
            wdata_d = wdata;
            cnt_d   = '0;
          end
        end
      end

      S_BUSY: begin
        // An ack arriving in the final allowed cycle still completes the access.
        if (mem.mem_ack) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          state_d = S_ERR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ERR: begin
        req_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign rdata = rdata_q;
  assign done  = (state_q == S_DONE);
  assign err   = (state_q == S_ERR);
  // A request seen in IDLE or DONE stalls the controller in the same cycle.
  assign busy  = (state_q == S_BUSY) || (state_q == S_ERR) ||
                 (((state_q == S_IDLE) || (state_q == S_DONE)) && req_in);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the access protocol.
module tb_mem_access_unit;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          done;
  logic          busy;
  logic          err;

  mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .done  (done),
    .busy  (busy),
    .err   (err),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks after a chosen number of mem_req cycles (0 = first cycle).
  int          force_lat    = -1;
  bit          force_rd_en  = 1'b0;
  logic [31:0] force_rd_val = '0;
  bit          spurious_en  = 1'b0;
  bit          inject_ack   = 1'b0;

  initial begin
    int lat_left;
    bit in_acc;
    int r;
    lat_left = 0;
    in_acc   = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (inject_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
      end else if (bus.mem_req) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          if (force_lat >= 0) lat_left = force_lat;
          else begin
            r = $urandom_range(0, 9);
            lat_left = (r < 9) ? $urandom_range(0, TIMEOUT - 1) : TIMEOUT + 1;
          end
        end
        if (lat_left == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = force_rd_en ? force_rd_val : $urandom;
        end
        lat_left--;
      end else begin
        in_acc = 1'b0;
        if (spurious_en && $urandom_range(0, 7) == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Transaction-level model: an access is either outstanding, just finished, or the unit is faulted.
  bit          m_err    = 1'b0;
  bit          m_pend   = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_we     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_rdata  = '0;
  int          m_waited = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_err    <= 1'b0;
      m_pend   <= 1'b0;
      m_done   <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rdata  <= '0;
      m_waited <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_err) begin
        m_err <= 1'b1;
      end else if (m_pend) begin
        if (bus.mem_ack) begin
          m_pend <= 1'b0;
          m_done <= 1'b1;
          if (!m_we) m_rdata <= bus.mem_rdata;
        end else if (TIMEOUT != 0 && m_waited + 1 >= TIMEOUT) begin
          m_pend <= 1'b0;
          m_err  <= 1'b1;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (rd_en || wr_en) begin
        if ((rd_en && wr_en) || (addr % 4 != 0)) begin
          m_err <= 1'b1;
        end else begin
          m_pend   <= 1'b1;
          m_we     <= wr_en;
          m_addr   <= addr;
          m_wdata  <= wdata;
          m_waited <= 0;
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_req", bus.mem_req, m_pend);
      check("done", done, m_done);
      check("err", err, m_err);
      check("busy", busy, m_err || m_pend || rd_en || wr_en);
      check("rdata", rdata, m_rdata);
      if (m_pend) begin
        check("mem_we", bus.mem_we, m_we);
        check("mem_addr", bus.mem_addr, m_addr);
        if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  task automatic do_reset();
    step();
    rst   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #2;
    rst    = 1'b0;
    cmp_en = 1'b1;
    step();
    step();
    rst = 1'b1;
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_req", bus.mem_req, 1'b0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_busy", busy, 1'b0);

    // T1: read 0x100, ack in third mem_req cycle.
    step();
    force_lat = 2; force_rd_en = 1'b1; force_rd_val = 32'hDEAD_BEEF;
    rd_en = 1'b1; addr = 32'h100;
    #2 check("t1_busy_c0", busy, 1'b1);
    check("t1_req_c0", bus.mem_req, 1'b0);
    step(); rd_en = 1'b0;
    #2 check("t1_req_c1", bus.mem_req, 1'b1);
    check("t1_addr_c1", bus.mem_addr, 32'h100);
    step(); #2 check("t1_req_c2", bus.mem_req, 1'b1);
    step(); #2 check("t1_req_c3", bus.mem_req, 1'b1);
    step(); #2 check("t1_req_c4", bus.mem_req, 1'b0);
    check("t1_done_c4", done, 1'b1);
    check("t1_rdata_c4", rdata, 32'hDEAD_BEEF);
    check("t1_busy_c4", busy, 1'b0);
    check("t1_model_rdata", m_rdata, 32'hDEAD_BEEF);
    step(); #2 check("t1_done_c5", done, 1'b0);

    // T2: write 0x204, ack with first mem_req cycle; T3 issues a read in its DONE cycle.
    step();
    force_lat = 0;
    wr_en = 1'b1; addr = 32'h204; wdata = 32'h1234_5678;
    step(); wr_en = 1'b0;
    #2 check("t2_req_c1", bus.mem_req, 1'b1);
    check("t2_we_c1", bus.mem_we, 1'b1);
    check("t2_addr_c1", bus.mem_addr, 32'h204);
    check("t2_wdata_c1", bus.mem_wdata, 32'h1234_5678);
    step();
    force_lat = 1; force_rd_val = 32'h0BAD_F00D;
    rd_en = 1'b1; addr = 32'h300;
    #2 check("t2_done_c2", done, 1'b1);
    check("t2_rdata_kept", rdata, 32'hDEAD_BEEF);
    step(); rd_en = 1'b0;
    #2 check("t3_req_c3", bus.mem_req, 1'b1);
    check("t3_addr_c3", bus.mem_addr, 32'h300);
    check("t3_we_c3", bus.mem_we, 1'b0);
    step(); #2 check("t3_req_c4", bus.mem_req, 1'b1);
    step(); #2 check("t3_done_c5", done, 1'b1);
    check("t3_rdata_c5", rdata, 32'h0BAD_F00D);

    // T4: never acked; mem_req lasts TIMEOUT cycles, then sticky error.
    step();
    force_lat = 1000;
    rd_en = 1'b1; addr = 32'h40;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(); rd_en = 1'b0;
      #2 check("t4_req_high", bus.mem_req, 1'b1);
    end
    step(); #2 check("t4_req_low", bus.mem_req, 1'b0);
    check("t4_err", err, 1'b1);
    check("t4_busy", busy, 1'b1);
    step(); rd_en = 1'b1; addr = 32'h0;
    step(); rd_en = 1'b0;
    #2 check("t4_err_held", err, 1'b1);
    check("t4_req_ignored", bus.mem_req, 1'b0);
    do_reset();
    #2 check("t4_err_cleared", err, 1'b0);

    // T5: misaligned address, then conflicting request.
    step(); rd_en = 1'b1; addr = 32'h102;
    step(); rd_en = 1'b0;
    #2 check("t5_mis_err", err, 1'b1);
    check("t5_mis_req", bus.mem_req, 1'b0);
    do_reset();
    step(); rd_en = 1'b1; wr_en = 1'b1; addr = 32'h0;
    step(); rd_en = 1'b0; wr_en = 1'b0;
    #2 check("t5_both_err", err, 1'b1);
    check("t5_both_req", bus.mem_req, 1'b0);
    do_reset();

    // T6: reset mid-access, stray ack afterwards, then a clean read.
    step(); force_lat = 1000; rd_en = 1'b1; addr = 32'h10;
    step(); rd_en = 1'b0;
    step();
    #3 rst = 1'b0;
    #1 check("t6_req_rst", bus.mem_req, 1'b0);
    check("t6_busy_rst", busy, 1'b0);
    check("t6_done_rst", done, 1'b0);
    check("t6_err_rst", err, 1'b0);
    step(); rst = 1'b1; inject_ack = 1'b1;
    step(); inject_ack = 1'b0;
    #2 check("t6_rdata_ignored", rdata, 32'h0);
    check("t6_done_ignored", done, 1'b0);
    force_lat = 0; force_rd_val = 32'hCAFE_F00D;
    step(); rd_en = 1'b1; addr = 32'h8;
    step(); rd_en = 1'b0;
    #2 check("t6_req_fresh", bus.mem_req, 1'b1);
    step(); #2 check("t6_done_fresh", done, 1'b1);
    check("t6_rdata_fresh", rdata, 32'hCAFE_F00D);

    // Random traffic.
    force_lat = -1; force_rd_en = 1'b0; spurious_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (m_err) begin
        do_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        rd_en = 1'b0; wr_en = 1'b0;
        #3 rst = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        int r;
        r = $urandom_range(0, 99);
        rd_en = (r < 40) || (r == 99);
        wr_en = (r >= 40 && r < 70) || (r == 99);
        addr  = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 29) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        wdata = $urandom;
      end
    end
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
